ppg_afe_model: RTL and testbench
================================

// Module: ppg_afe_model
// PURPOSE
//  Synthesisable model of the pulse-oximeter analog front end: photodiode, DC-comp DAC, PGA, 8-bit ADC.
//  Consumes the controller's LED_RED/LED_IR/LED_DRIVE/DC_Comp/PGA_Gain outputs and returns ADC samples.
//  Produces a triangular synthetic PPG pulse per channel; closes the DC/PGA calibration loop in sim and FPGA.
// PARAMETERS
//  RED_BASE       180  photodiode DC level, RED channel, at LED_DRIVE=8
//  IR_BASE        160  photodiode DC level, IR channel, at LED_DRIVE=8
//  DARK_LEVEL     0    photodiode level when no single LED is selected
//  AC_AMP         8    triangle pulse amplitude, 0..63
//  BEAT_DIV       16   CLK cycles per triangle step, >=1
//  DC_STEP        2    photo-level units removed per DC_Comp LSB
//  SETTLE_CYCLES  2    invalid cycles after a channel change, 0..15
// PORTS
//  CLK        in   1  system clock, one sample per cycle
//  rst_n      in   1  asynchronous reset, active low
//  LED_RED    in   1  RED LED enable
//  LED_IR     in   1  IR LED enable
//  LED_DRIVE  in   4  LED current code
//  DC_Comp    in   7  DC compensation code; higher code lowers ADC
//  PGA_Gain   in   4  PGA code; gain = PGA_Gain+1
//  ADC        out  8  converted sample
//  ADC_valid  out  1  ADC is a settled sample of the current channel
//  Clip       out  1  current ADC value was saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): ADC=0, ADC_valid=0, Clip=0.
//  - Internal reset state: tri=0, dir=up, prescaler=0, prev_sel=DARK, settle_cnt=SETTLE_CYCLES.
//  - Reset mid-operation aborts the pipeline. No partial sample is emitted after release.
//  Channel select (comb): RED if LED_RED&~LED_IR; IR if LED_IR&~LED_RED; else DARK. Both on counts as DARK.
//  Pulse generator:
//  - tri is signed 8b. Prescaler counts 0..BEAT_DIV-1 and steps tri on wrap.
//  - Step up: tri==AC_AMP ? (dir<=down, tri-1) : tri+1. Step down mirrors this at -AC_AMP.
//  - Period = 4*AC_AMP*BEAT_DIV cycles. AC_AMP=0 holds tri at 0.
//  Stage 1 (registered at edge k):
//  - photo = DARK ? DARK_LEVEL : ((BASE+tri)*LED_DRIVE)>>3. Unsigned 12b; base+tri is clamped at 0.
//  - centered = photo - DC_Comp*DC_STEP, signed 14b. v1 = (settle_cnt==0).
//  Stage 2 (edge k+1):
//  - amp = centered*(PGA_Gain+1), signed 18b. s = 128+amp.
//  - ADC = sat(s,0,255); Clip = (s<0 | s>255). ADC_valid = v1.
//  - PGA_Gain is sampled in stage 1 together with the other inputs, so all inputs share one sample.
//  - When v1=0: ADC and Clip hold their previous values and ADC_valid=0.
//  Latency: inputs sampled at edge k appear on ADC after edge k+1 (2 cycles). Fully pipelined, 1 sample/cycle.
//  Settle:
//  - sel!=prev_sel at an edge: settle_cnt<=SETTLE_CYCLES, prev_sel<=sel. Otherwise it decrements to 0 and stops.
//  - A change during settling restarts the count.
//  - DC_Comp, PGA_Gain and LED_DRIVE changes do not trigger settling.
//  Boundaries:
//  - LED_DRIVE=0 gives photo=0.
//  - DC_Comp=127 with DC_STEP=2 subtracts 254.
//  - PGA_Gain=15 gives x16; saturation is mandatory and must never wrap.
//  - Triangle turnaround hits the exact +/-AC_AMP endpoints once per half period.
// CONFIGURATION
//  AFE_NOISE_EN defined:
//  - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 on reset, advances every cycle.
//  - Signed LFSR[2:0]-4 (range -4..+3) is added to photo in stage 1; the result is clamped at 0.
//  AFE_NOISE_EN undefined: no LFSR, output fully deterministic. All TESTING values assume undefined.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> ADC=0, ADC_valid=0, Clip=0 immediately; valid again SETTLE_CYCLES+2 cycles after release with a stable select.
//  2 Static RED: AC_AMP=0, LED_RED=1, LED_DRIVE=10, DC_Comp=112, PGA_Gain=0 -> photo=225, ADC=129, Clip=0; with PGA_Gain=3 -> ADC=132.
//  3 Saturation: setup of test 2 with DC_Comp=0 -> ADC=255, Clip=1; DC_Comp=127, PGA_Gain=15 -> s=128-464 -> ADC=0, Clip=1.
//  4 Switch RED->IR, DC_Comp=100: ADC_valid low for exactly SETTLE_CYCLES samples with ADC held, then ADC=128 (IR photo=200).
//  5 Both LEDs on, DC_Comp=0, DARK_LEVEL=0 -> ADC=128; LED_DRIVE=0 with RED selected, DC_Comp=0 -> ADC=128.
//  6 Pulse: AC_AMP=4, BEAT_DIV=1, LED_DRIVE=8, RED, DC_Comp=90, PGA 0 -> ADC cycles 128..132..124 (180+tri-180+128), period 16, no repeated endpoints.

Source files
------------

// File: rtl/ppg_afe_model.sv
// ppg_afe_model: synthesisable pulse-oximeter analog front end model.
// Photodiode with triangular synthetic PPG pulse, DC-compensation DAC,
// PGA and saturating 8-bit ADC, two-stage pipeline with channel settling.
// Optional feature macro: AFE_NOISE_EN adds LFSR noise to the photo level.
module ppg_afe_model #(
  parameter int RED_BASE      = 180,
  parameter int IR_BASE       = 160,
  parameter int DARK_LEVEL    = 0,
  parameter int AC_AMP        = 8,
  parameter int BEAT_DIV      = 16,
  parameter int DC_STEP       = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [3:0] LED_DRIVE,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] ADC,
  output logic       ADC_valid,
  output logic       Clip
);

  localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic signed [7:0] AMP_P = 8'(AC_AMP);
  localparam logic signed [7:0] AMP_N = -8'(AC_AMP);

  typedef enum logic [1:0] {SEL_DARK = 2'd0, SEL_RED = 2'd1, SEL_IR = 2'd2} sel_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  sel_e              sel, prev_sel;
  dir_e              dir, dir_nxt;
  logic signed [7:0] tri_val, tri_nxt;
  logic [PW-1:0]     presc;
  logic              presc_wrap;
  logic [3:0]        settle_cnt, settle_nxt;

  logic signed [9:0]  base_s, tri_ext, lvl;
  logic [8:0]         lvl_u;
  logic [12:0]        prod;
  logic [11:0]        photo, photo_c;
  logic [13:0]        comp;
  logic signed [13:0] centered;

  logic signed [13:0] centered_r;
  logic [3:0]         gain_r;
  logic               v1_r;

  logic [4:0]         gain_p1;
  logic signed [17:0] cent_ext, amp, s;
  logic [7:0]         adc_sat;
  logic               clip_c;

  // Channel select: exactly one LED on selects that channel, otherwise dark.
  always_comb begin
    sel = SEL_DARK;
    if (LED_RED && !LED_IR)      sel = SEL_RED;
    else if (LED_IR && !LED_RED) sel = SEL_IR;
  end

  // Triangle next state: turn around at the exact endpoints, hold when amplitude is zero.
  always_comb begin
    presc_wrap = (presc == PW'(BEAT_DIV - 1));
    tri_nxt    = tri_val;
    dir_nxt    = dir;
    if (presc_wrap && (AMP_P != 8'sd0)) begin
      if (dir == DIR_UP) begin
        if (tri_val == AMP_P) begin
          dir_nxt = DIR_DOWN;
          tri_nxt = tri_val - 8'sd1;
        end else begin
          tri_nxt = tri_val + 8'sd1;
        end
      end else begin
        if (tri_val == AMP_N) begin
          dir_nxt = DIR_UP;
          tri_nxt = tri_val + 8'sd1;
        end else begin
          tri_nxt = tri_val - 8'sd1;
        end
      end
    end
  end

  // Pulse generator state: prescaler and triangle register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      tri_val <= '0;
      dir     <= DIR_UP;
    end else begin
      presc   <= presc_wrap ? '0 : presc + PW'(1);
      tri_val <= tri_nxt;
      dir     <= dir_nxt;
    end
  end

  // Settle counter next value: restart on any channel change, else count down to zero.
  always_comb begin
    settle_nxt = settle_cnt;
    if (sel != prev_sel)        settle_nxt = 4'(SETTLE_CYCLES);
    else if (settle_cnt != 4'd0) settle_nxt = settle_cnt - 4'd1;
  end

  // Photodiode level, DC compensation and centring.
  always_comb begin
    base_s  = (sel == SEL_RED) ? 10'(RED_BASE) : 10'(IR_BASE);
    tri_ext = {{2{tri_val[7]}}, tri_val};
    lvl     = base_s + tri_ext;
    lvl_u   = lvl[9] ? '0 : lvl[8:0];
    prod    = 13'(lvl_u) * 13'(LED_DRIVE);
    photo   = (sel == SEL_DARK) ? 12'(DARK_LEVEL) : 12'(prod >> 3);
    comp    = 14'(DC_Comp) * 14'(DC_STEP);
    centered = $signed({2'b00, photo_c}) - $signed(comp);
  end

`ifdef AFE_NOISE_EN
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic signed [13:0] noise, photo_sum;

  // Noise LFSR, x^16+x^14+x^13+x^11+1, advances every cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Add -4..+3 noise to the photo level, clamped at zero.
  always_comb begin
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    noise     = $signed({11'b0, lfsr[2:0]}) - 14'sd4;
    photo_sum = $signed({2'b00, photo}) + noise;
    photo_c   = photo_sum[13] ? '0 : 12'(photo_sum);
  end
`else
  // Deterministic build: photo level passes through unchanged.
  always_comb begin
    photo_c = photo;
  end
`endif

  // Stage 1: register centred sample, gain and validity; track channel settling.
  // Validity uses the settle count as updated at this same edge, so a channel
  // change yields exactly SETTLE_CYCLES invalid samples.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      centered_r <= '0;
      gain_r     <= '0;
      v1_r       <= 1'b0;
      prev_sel   <= SEL_DARK;
      settle_cnt <= 4'(SETTLE_CYCLES);
    end else begin
      centered_r <= centered;
      gain_r     <= PGA_Gain;
      v1_r       <= (settle_nxt == 4'd0);
      prev_sel   <= sel;
      settle_cnt <= settle_nxt;
    end
  end

  // PGA gain and saturating conversion.
  always_comb begin
    gain_p1  = {1'b0, gain_r} + 5'd1;
    cent_ext = {{4{centered_r[13]}}, centered_r};
    amp      = cent_ext * $signed({13'b0, gain_p1});
    s        = amp + 18'sd128;
    clip_c   = (s < 18'sd0) || (s > 18'sd255);
    if (s < 18'sd0)        adc_sat = 8'd0;
    else if (s > 18'sd255) adc_sat = 8'd255;
    else                   adc_sat = s[7:0];
  end

  // Stage 2: update the ADC outputs only for settled samples, otherwise hold.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ADC       <= '0;
      Clip      <= 1'b0;
      ADC_valid <= 1'b0;
    end else begin
      ADC_valid <= v1_r;
      if (v1_r) begin
        ADC  <= adc_sat;
        Clip <= clip_c;
      end
    end
  end

endmodule

// File: tb/tb_ppg_afe_model.sv
// tb_ppg_afe_model: directed self-checking bench for ppg_afe_model.
// Instance dut holds the pulse at zero for static checks; dut_p runs a
// fast four-step triangle for the pulse checks.
module tb_ppg_afe_model;

  logic       CLK;
  logic       rst_n;
  logic       LED_RED, LED_IR;
  logic [3:0] LED_DRIVE;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;

  logic [7:0] adc, adc_p;
  logic       valid, valid_p, clip, clip_p;

  int n_checks = 0;
  int n_fail   = 0;

  ppg_afe_model #(.AC_AMP(0)) dut (
    .CLK(CLK), .rst_n(rst_n), .LED_RED(LED_RED), .LED_IR(LED_IR),
    .LED_DRIVE(LED_DRIVE), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .ADC(adc), .ADC_valid(valid), .Clip(clip)
  );

  ppg_afe_model #(.AC_AMP(4), .BEAT_DIV(1)) dut_p (
    .CLK(CLK), .rst_n(rst_n), .LED_RED(LED_RED), .LED_IR(LED_IR),
    .LED_DRIVE(LED_DRIVE), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .ADC(adc_p), .ADC_valid(valid_p), .Clip(clip_p)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_in(input logic red, input logic ir, input int drv, input int dc, input int pga);
    LED_RED   = red;
    LED_IR    = ir;
    LED_DRIVE = 4'(drv);
    DC_Comp   = 7'(dc);
    PGA_Gain  = 4'(pga);
  endtask

  // Expected pulse ADC after the first valid edge: 128 + tri, period 16.
  int pulse_tbl [16] = '{130, 131, 132, 131, 130, 129, 128, 127,
                         126, 125, 124, 125, 126, 127, 128, 129};

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 10, 112, 0);
    tick(2);
    check("rst_adc",   adc,   0);
    check("rst_valid", valid, 0);
    check("rst_clip",  clip,  0);
    rst_n = 1'b1;
    tick(6);

    // Static RED: photo 225, centred 1.
    check("red_adc",   adc,   129);
    check("red_valid", valid, 1);
    check("red_clip",  clip,  0);
    set_in(1'b1, 1'b0, 10, 112, 3);
    tick(3);
    check("red_pga3", adc, 132);

    // Saturation high and low.
    set_in(1'b1, 1'b0, 10, 0, 0);
    tick(3);
    check("sat_hi_adc",  adc,  255);
    check("sat_hi_clip", clip, 1);
    set_in(1'b1, 1'b0, 10, 127, 15);
    tick(3);
    check("sat_lo_adc",  adc,  0);
    check("sat_lo_clip", clip, 1);

    // RED -> IR switch with DC_Comp=100: RED gives 153, IR gives 128.
    set_in(1'b1, 1'b0, 10, 100, 0);
    tick(3);
    check("pre_sw_adc",  adc,  153);
    check("pre_sw_clip", clip, 0);
    set_in(1'b0, 1'b1, 10, 100, 0);
    tick(1);
    check("sw0_valid", valid, 1);
    check("sw0_adc",   adc,   153);
    tick(1);
    check("sw1_valid", valid, 0);
    check("sw1_adc",   adc,   153);
    tick(1);
    check("sw2_valid", valid, 0);
    check("sw2_adc",   adc,   153);
    tick(1);
    check("sw3_valid", valid, 1);
    check("sw3_adc",   adc,   128);

    // Both LEDs on is dark.
    set_in(1'b1, 1'b1, 10, 0, 0);
    tick(5);
    check("dark_adc",   adc,   128);
    check("dark_valid", valid, 1);
    check("dark_clip",  clip,  0);
    // LED_DRIVE=0 gives zero photo.
    set_in(1'b1, 1'b0, 0, 0, 0);
    tick(5);
    check("drv0_adc",   adc,   128);
    check("drv0_valid", valid, 1);

    // Mid-stream reset and recovery with RED held.
    set_in(1'b1, 1'b0, 10, 112, 0);
    tick(5);
    check("pre_rst_adc", adc, 129);
    rst_n = 1'b0;
    #1;
    check("mrst_adc",   adc,   0);
    check("mrst_valid", valid, 0);
    check("mrst_clip",  clip,  0);
    tick(1);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      check("rec_valid_lo", valid, 0);
      check("rec_adc_held", adc,   0);
    end
    tick(1);
    check("rec_valid_hi", valid, 1);
    check("rec_adc",      adc,   129);

    // Pulse: RED at drive 8, DC_Comp=90 -> ADC = 128 + tri.
    set_in(1'b1, 1'b0, 8, 90, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("pulse_pre_valid", valid_p, 0);
    for (int i = 0; i < 32; i++) begin
      tick(1);
      check("pulse_adc",   adc_p,   pulse_tbl[i % 16]);
      check("pulse_valid", valid_p, 1);
    end
    check("pulse_clip", clip_p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
